// File: rtl/div32x32_fast_fsm_pkg.sv
// Shared types and constants for the 32/32 unsigned restoring divider.
package div32_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;
  // Wide enough to hold the iteration count DATA_W (32).
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div32x32_fast_fsm_if.sv
// Request/result bundle of the divider: master issues requests, slave answers.
interface div32x32_fast_fsm_if;
  import div32_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div32x32_fast_fsm_step.sv
// One restoring-division step: shift in one dividend bit, try to subtract.
module div32_step
  import div32_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic              shift_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0]          shifted;
  logic signed [DATA_W+1:0] trial;

  // Shifted remainder can reach 33 bits; the sign of the trial decides the bit.
  always_comb begin
    shifted = {rem_in, shift_in};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, divisor});
    if (trial >= 0) begin
      q_bit   = 1'b1;
      rem_out = trial[DATA_W-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/div32x32_fast_fsm.sv
// Multi-cycle 32/32 unsigned divider; 16 iterations when the dividend fits
// in 16 bits, 32 otherwise, single-cycle answer for a zero divisor.
module div32x32_fast_fsm
  import div32_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  div32x32_fast_fsm_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] prem_q, prem_d;
  logic [DATA_W-1:0] quo_w_q, quo_w_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] step_rem;
  logic              step_qbit;
  logic [DATA_W-1:0] quo_next;

  div32_step u_step (
    .rem_in   (prem_q),
    .shift_in (shreg_q[DATA_W-1]),
    .divisor  (divisor_q),
    .rem_out  (step_rem),
    .q_bit    (step_qbit)
  );

  assign quo_next = {quo_w_q[DATA_W-2:0], step_qbit};

  // Next-state and next-register values; results only move on completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    shreg_d     = shreg_q;
    prem_d      = prem_q;
    quo_w_d     = quo_w_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.b == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.a;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            dbz_d     = 1'b0;
            divisor_d = bus.b;
            prem_d    = '0;
            quo_w_d   = '0;
            if (bus.a[DATA_W-1:HALF_W] == '0) begin
              cnt_d   = CNT_W'(HALF_W);
              shreg_d = {bus.a[HALF_W-1:0], {HALF_W{1'b0}}};
            end else begin
              cnt_d   = CNT_W'(DATA_W);
              shreg_d = bus.a;
            end
            state_d = DIV;
          end
        end
      end
      DIV: begin
        prem_d  = step_rem;
        quo_w_d = quo_next;
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quotient_d  = quo_next;
          remainder_d = step_rem;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state, working and output registers; async reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      shreg_q     <= '0;
      prem_q      <= '0;
      quo_w_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      shreg_q     <= shreg_d;
      prem_q      <= prem_d;
      quo_w_q     <= quo_w_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32x32_fast_fsm.sv
// Directed bench for the fast-path 32/32 divider.
module tb_div32x32_fast_fsm;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  div32x32_fast_fsm_if dif ();

  div32x32_fast_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one start pulse and return the cycle number (start cycle = 0) of done.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    lat = 1;
    while (dif.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen_done;
    total = 0;
    bad   = 0;
    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 17};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[2]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[3]  = '{32'h0001_0000,  32'h0002_0000,  32'd0,          32'h0001_0000,  1'b0, 33};
    vecs[4]  = '{32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 17};
    vecs[5]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 17};
    vecs[6]  = '{32'd12345,      32'd1,          32'd12345,      32'd0,          1'b0, 17};
    vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    vecs[8]  = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 33};
    vecs[9]  = '{32'h0000_FFFF,  32'h0000_FFFF,  32'd1,          32'd0,          1'b0, 17};
    vecs[10] = '{32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF,  1'b0, 33};
    vecs[11] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};

    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_quot", dif.quotient, 32'd0);
    chk("rst_rem",  dif.remainder, 32'd0);
    chk("rst_dbz",  32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(dif.busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(dif.busy), 32'd1);
      chk($sformatf("v%0d_quot", i), dif.quotient, vecs[i].q);
      chk($sformatf("v%0d_rem", i), dif.remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), 32'(dif.div_by_zero), 32'(vecs[i].dbz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), 32'(dif.done), 32'd0);
      chk($sformatf("v%0d_idle", i), 32'(dif.busy), 32'd0);
    end

    // start held high through a run; a second request rides on the same level
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 32'd1000;
    dif.b     = 32'd10;
    @(posedge clk);
    #1;
    dif.a = 32'd50;
    dif.b = 32'd0;
    lat   = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_quot_mid", dif.quotient, 32'hFFFF_FFFF);
    chk("hold_rem_mid", dif.remainder, 32'd0);
    chk("hold_busy_mid", 32'(dif.busy), 32'd1);
    while (dif.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd17);
    chk("hold_quot", dif.quotient, 32'd100);
    chk("hold_rem", dif.remainder, 32'd0);
    chk("hold_dbz", 32'(dif.div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    chk("gap_busy", 32'(dif.busy), 32'd0);
    chk("gap_done", 32'(dif.done), 32'd0);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk("second_done", 32'(dif.done), 32'd1);
    chk("second_dbz", 32'(dif.div_by_zero), 32'd1);
    chk("second_quot", dif.quotient, 32'hFFFF_FFFF);
    chk("second_rem", dif.remainder, 32'd50);
    @(posedge clk);
    #1;

    // reset in the middle of a 32-iteration run aborts it
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 32'hFFFF_FFFF;
    dif.b     = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_pre", 32'(dif.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_quot", dif.quotient, 32'd0);
    chk("abort_rem", dif.remainder, 32'd0);
    chk("abort_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div32x32_fast_fsm.md
DIV32X32_FAST_FSM -- requirements
Module: div32x32_fast_fsm

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  32  unsigned dividend; sampled in the start cycle.
REQ-006 b  input  32  unsigned divisor; sampled in the start cycle.
REQ-007 busy  output  1  high in DIV and DONE, low in IDLE.
REQ-008 done  output  1  single-cycle pulse; high only in DONE.
REQ-009 quotient  output  32  result quotient; valid from DONE until the next accepted start.
REQ-010 remainder  output  32  result remainder; valid from DONE until the next accepted start.
REQ-011 div_by_zero  output  1  result flag; valid and held over the same window as quotient and remainder.

Function
REQ-012 The FSM SHALL have three states: IDLE, DIV and DONE.
REQ-013 IDLE, start=0: the FSM SHALL stay in IDLE with busy=0 and done=0.
REQ-014 IDLE, start=1, b==0 (start cycle T): the FSM SHALL set div_by_zero=1, quotient=32'hFFFF_FFFF and remainder=a, then go to DONE at T+1.
REQ-015 IDLE, start=1, b!=0: the FSM SHALL clear div_by_zero, latch b, clear the partial remainder and go to DIV.
REQ-016 Fast path: if a[31:16]==0, the iteration count N SHALL be 16 and the shift register SHALL be preloaded with {a[15:0],16'h0}.
REQ-017 Normal path: if a[31:16]!=0, N SHALL be 32 and the shift register SHALL be preloaded with a.
REQ-018 DIV, each cycle: the partial remainder SHALL be shifted left by one bit, taking the shift register MSB as its new LSB.
REQ-019 DIV, each cycle: trial = shifted remainder - divisor, computed 33 bits wide; if trial>=0, the remainder SHALL take trial and the quotient LSB SHALL be 1, otherwise the remainder is kept and the quotient LSB SHALL be 0.
REQ-020 DIV: the iteration counter SHALL decrement every cycle; after the Nth iteration the FSM SHALL go to DONE.
REQ-021 Latency: a start at cycle T SHALL give done=1 at T+N+1 (T+17 fast, T+33 normal, T+1 divide-by-zero).
REQ-022 DONE: done=1 and busy=1 for exactly one cycle, then unconditionally IDLE.
REQ-023 A start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-024 The first start accepted in IDLE after DONE SHALL begin a new operation; there is no idle gap requirement.
REQ-025 quotient, remainder and div_by_zero SHALL update only at completion and SHALL hold otherwise; internal working registers SHALL be separate from the output registers.
REQ-026 a=0 SHALL use the fast path and give quotient=0, remainder=0.
REQ-027 a<b SHALL give quotient=0, remainder=a.
REQ-028 b=1 SHALL give quotient=a, remainder=0.

Reset
REQ-029 On reset the FSM SHALL go to IDLE, and busy, done, quotient, remainder, div_by_zero and all counters SHALL be 0.
REQ-030 A reset asserted in DIV or DONE SHALL abort the operation; no done pulse SHALL follow the release of reset.

Structure
REQ-031 Package div32_pkg SHALL hold the state enum (IDLE, DIV, DONE) and the constants DATA_W=32, HALF_W=16 and the counter width.
REQ-032 One combinational sub-module, div32_step, SHALL compute one restoring step: inputs remainder, shift-in bit and divisor; outputs the next remainder and the quotient bit.
REQ-033 The FSM, counter and registers SHALL live in div32x32_fast_fsm.

Verification
REQ-034 a=100, b=7, start at T -> done at T+17, quotient=14, remainder=2, div_by_zero=0.
REQ-035 a=32'hFFFF_FFFF, b=1 -> done at T+33, quotient=32'hFFFF_FFFF, remainder=0.
REQ-036 a=5, b=0 -> done at T+1, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=5.
REQ-037 a=32'h0001_0000, b=32'h0002_0000 -> done at T+33, quotient=0, remainder=32'h0001_0000.
REQ-038 start held high through a run with a=1000, b=10, followed by a second start -> the first result is quotient=100, remainder=0, and the second operation begins only at the IDLE cycle after done.
REQ-039 reset pulsed at T+5 of a 32-iteration run -> busy=0 and all outputs 0 next cycle, and no done pulse follows.
